regfile_dump_reader: RTL and testbench

- Read-side companion to the CPU register file: walks a range of register addresses through one register-file read port and streams each word out over a valid/ready handshake.
- Used for debug dump, end-of-test register checking and state snapshot.
- Sits beside the register file and shares its clock. It drives one read address and samples the combinational read data.

---
 rtl/cpu_pkg.sv | 19 +
 rtl/regfile_dump_reader_walker.sv | 48 ++++
 rtl/regfile_dump_reader.sv | 101 ++++++++++
 tb/tb_regfile_dump_reader.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared register-file parameters and the dump reader's state encoding.
package cpu_pkg;

  localparam int MEMORY_WIDTH = 32;
  localparam int REGISTER_NUM = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    SEND   = 2'd2,
    FINISH = 2'd3
  } dump_state_t;

  // A single-entry register file still needs a one-bit address.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regfile_dump_reader_walker.sv
// Address/remaining counters for a dump: modulo-register_num address walk, saturated count.
// Loads in one cycle, advances once per accepted word; last flags the final word.
module regfile_addr_walker
  import cpu_pkg::*;
#(
  parameter  int register_num = REGISTER_NUM,
  localparam int ADDR_W       = addr_w(register_num),
  localparam int CNT_W        = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [CNT_W-1:0]  remaining;
  logic [CNT_W-1:0]  count_sat;
  logic [ADDR_W-1:0] addr_mod;
  logic [ADDR_W-1:0] addr_next;

  // start_addr < 2*register_num, so one conditional subtract is a full modulo.
  always_comb begin
    count_sat = (word_count > CNT_W'(register_num)) ? CNT_W'(register_num) : word_count;
    addr_mod  = ({1'b0, start_addr} >= CNT_W'(register_num))
              ? start_addr - ADDR_W'(register_num) : start_addr;
    addr_next = (addr == ADDR_W'(register_num - 1)) ? '0 : addr + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= addr_mod;
      remaining <= count_sat;
    end else if (advance) begin
      addr      <= addr_next;
      remaining <= remaining - 1'b1;
    end
  end

  assign last = (remaining == CNT_W'(1));

endmodule

// File: rtl/regfile_dump_reader.sv
// Streams a range of register-file words over valid/ready, one word per two cycles at best.
// A stalled word holds out_* stable; the next register is only fetched after a transfer.
module regfile_dump_reader
  import cpu_pkg::*;
#(
  parameter  int memory_width = MEMORY_WIDTH,
  parameter  int register_num = REGISTER_NUM,
  localparam int ADDR_W       = addr_w(register_num)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       start_addr,
  input  logic [ADDR_W:0]         word_count,
  output logic [ADDR_W-1:0]       rf_readAddr,
  input  logic [memory_width-1:0] rf_readData,
  output logic [memory_width-1:0] out_data,
  output logic [ADDR_W-1:0]       out_addr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last,
  output logic                    busy,
  output logic                    done
);

  dump_state_t       state;
  logic [ADDR_W-1:0] addr;
  logic              last;
  logic              load;
  logic              advance;

  assign load    = (state == IDLE) && start;
  assign advance = (state == SEND) && out_ready && !last;

  regfile_addr_walker #(.register_num(register_num)) u_walker (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .advance    (advance),
    .start_addr (start_addr),
    .word_count (word_count),
    .addr       (addr),
    .last       (last)
  );

  assign rf_readAddr = addr;

  // done is raised on entry to FINISH so it is high for exactly the FINISH cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      out_data  <= '0;
      out_addr  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (word_count == '0) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end
        end
        FETCH: begin
          out_data  <= rf_readData;
          out_addr  <= addr;
          out_valid <= 1'b1;
          out_last  <= last;
          state     <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (last) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end
        end
        FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader with a behavioural register file.
module tb_regfile_dump_reader;
  import cpu_pkg::*;

  localparam int MW = 32;
  localparam int RN = 32;
  localparam int AW = 5;
  localparam int CW = AW + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] start_addr = '0;
  logic [CW-1:0] word_count = '0;
  logic [AW-1:0] rf_readAddr;
  logic [MW-1:0] rf_readData;
  logic [MW-1:0] out_data;
  logic [AW-1:0] out_addr;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_last;
  logic          busy;
  logic          done;

  logic [MW-1:0] rf [RN];
  assign rf_readData = rf[rf_readAddr];

  regfile_dump_reader #(.memory_width(MW), .register_num(RN)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .word_count(word_count), .rf_readAddr(rf_readAddr), .rf_readData(rf_readData),
    .out_data(out_data), .out_addr(out_addr), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [MW-1:0] q_data [$];
  logic [AW-1:0] q_addr [$];
  logic          q_last [$];
  int poke_word  = -1;
  int write_word = -1;
  bit live_en    = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int sa, input int wc);
    int n;
    int a;
    n = (wc > RN) ? RN : wc;
    for (int i = 0; i < n; i++) begin
      a = ((sa % RN) + i) % RN;
      q_addr.push_back(AW'(a));
      q_data.push_back((live_en && a == 20) ? 32'hDEAD_BEEF : rf[a]);
      q_last.push_back(i == n - 1);
    end
    start_addr = AW'(sa);
    word_count = CW'(wc);
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  // Returns the number of clk edges from the start edge (counted as 1) to done.
  task automatic consume(input int stall_word, input int stall_len, input int budget,
                         output int cycles);
    int words = 0;
    int stalled = 0;
    bit fin = 1'b0;
    bit poked = 1'b0;
    logic [MW-1:0] hd = '0;
    logic [AW-1:0] ha = '0;
    cycles = 1;
    while (!fin) begin
      start = 1'b0;
      if (cycles > budget) begin
        checks++; errors++;
        $display("FAIL timeout: done not seen within %0d cycles", budget);
        fin = 1'b1;
      end else if (done) begin
        fin = 1'b1;
      end else begin
        if (!out_valid) begin
          checks++;
          if (out_last !== 1'b0) begin
            errors++;
            $display("FAIL last_without_valid: out_last=%b required 0", out_last);
          end
          out_ready = 1'b1;
        end else begin
          if (words == poke_word && !poked) begin
            start = 1'b1; start_addr = AW'(17); word_count = CW'(3); poked = 1'b1;
          end
          if (words == write_word) rf[20] = 32'hDEAD_BEEF;
          if (words == stall_word && stalled < stall_len) begin
            if (stalled == 0) begin
              hd = out_data; ha = out_addr;
            end else begin
              checks++;
              if (out_data !== hd || out_addr !== ha || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold: data=%h addr=%0d valid=%b required %h %0d 1",
                         out_data, out_addr, out_valid, hd, ha);
              end
            end
            out_ready = 1'b0;
            stalled++;
          end else begin
            out_ready = 1'b1;
            if (words == stall_word && stalled > 0) begin
              checks++;
              if (out_data !== hd || out_addr !== ha) begin
                errors++;
                $display("FAIL stall_release: data=%h addr=%0d required %h %0d",
                         out_data, out_addr, hd, ha);
              end
            end
            checks++;
            if (q_addr.size() == 0) begin
              errors++;
              $display("FAIL extra_word: addr=%0d data=%h required no word", out_addr, out_data);
            end else begin
              if (out_addr !== q_addr[0] || out_data !== q_data[0] || out_last !== q_last[0]) begin
                errors++;
                $display("FAIL word%0d: addr=%0d data=%h last=%b required %0d %h %b",
                         words, out_addr, out_data, out_last, q_addr[0], q_data[0], q_last[0]);
              end
              void'(q_addr.pop_front()); void'(q_data.pop_front()); void'(q_last.pop_front());
            end
            words++;
          end
        end
        tick();
        cycles++;
      end
    end
    out_ready = 1'b1;
  endtask

  task automatic finish_checks(input string name, input int cycles, input int exp_cycles);
    checks++;
    if (cycles !== exp_cycles) begin
      errors++;
      $display("FAIL %s_latency: done after %0d cycles required %0d", name, cycles, exp_cycles);
    end
    checks++;
    if (q_addr.size() != 0) begin
      errors++;
      $display("FAIL %s_missing: %0d words not seen required 0", name, q_addr.size());
      q_addr.delete(); q_data.delete(); q_last.delete();
    end
    checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_finish_state: busy=%b valid=%b required 1 0", name, busy, out_valid);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: done=%b busy=%b required 0 0", name, done, busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++;
    if (rf_readAddr !== '0 || out_data !== '0 || out_addr !== '0) begin
      errors++;
      $display("FAIL reset_data: rdaddr=%0d data=%h addr=%0d required 0 0 0",
               rf_readAddr, out_data, out_addr);
    end
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: valid=%b last=%b busy=%b done=%b required 0000",
               out_valid, out_last, busy, done);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_full_dump();
    int c;
    launch(0, 32);
    consume(-1, 0, 200, c);
    finish_checks("full", c, 65);
  endtask

  task automatic test_wrap();
    int c;
    launch(30, 4);
    consume(-1, 0, 50, c);
    finish_checks("wrap", c, 9);
  endtask

  task automatic test_backpressure();
    int c;
    launch(3, 6);
    consume(2, 5, 60, c);
    finish_checks("backpressure", c, 18);
  endtask

  task automatic test_zero_and_saturate();
    int c;
    launch(7, 0);
    consume(-1, 0, 10, c);
    finish_checks("zero", c, 1);
    launch(5, 33);
    consume(-1, 0, 200, c);
    finish_checks("saturate", c, 65);
  endtask

  task automatic test_start_while_busy();
    int c;
    poke_word = 3;
    launch(0, 8);
    consume(-1, 0, 60, c);
    poke_word = -1;
    finish_checks("busy_start", c, 17);
  endtask

  task automatic test_mid_reset();
    int c;
    bit found = 1'b0;
    launch(0, 32);
    q_addr.delete(); q_data.delete(); q_last.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 100 && !found; i++) begin
      if (out_valid && out_addr == AW'(10)) found = 1'b1;
      else tick();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_reset_reach: word 10 not seen required seen");
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_addr !== '0 || out_last !== 1'b0 ||
        busy !== 1'b0 || done !== 1'b0 || rf_readAddr !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: valid=%b data=%h addr=%0d last=%b busy=%b done=%b rd=%0d required all 0",
               out_valid, out_data, out_addr, out_last, busy, done, rf_readAddr);
    end
    launch(12, 3);
    consume(-1, 0, 30, c);
    finish_checks("after_reset", c, 7);
  endtask

  task automatic test_live_update();
    int c;
    live_en = 1'b1;
    write_word = 5;
    launch(0, 32);
    consume(-1, 0, 200, c);
    write_word = -1;
    live_en = 1'b0;
    finish_checks("live", c, 65);
  endtask

  initial begin
    for (int k = 0; k < RN; k++) rf[k] = 32'h1000_0000 + k;
    test_reset();
    test_full_dump();
    test_wrap();
    test_backpressure();
    test_zero_and_saturate();
    test_start_while_busy();
    test_mid_reset();
    test_live_update();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
